// File: rtl/pattern_scan_if.sv
// Handshake and status bundle between the scan controller and its host logic.
// The master drives command, configuration and serial data; the slave reports status.
interface pattern_scan_if #(
  parameter int PAT_W = 4,
  parameter int WIN_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic [WIN_W-1:0] cfg_win_len;
  logic             data;
  logic             data_valid;
  logic             busy;
  logic             match;
  logic             done;
  logic [CNT_W-1:0] match_count;

  modport master (
    output start, abort, cfg_pattern, cfg_win_len, data, data_valid,
    input  busy, match, done, match_count
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_win_len, data, data_valid,
    output busy, match, done, match_count
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Windowed serial pattern scanner: counts non-overlapping matches of a latched
// pattern over a software-sized window of valid bits, then pulses done.
module pattern_scan_ctrl #(
  parameter int PAT_W = 4,
  parameter int WIN_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  pattern_scan_if.slave    bus
);
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg;
  logic [PAT_W-1:0] pattern_reg;
  logic [WIN_W-1:0] win_reg;
  logic [PAT_W-2:0] hist_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [WIN_W-1:0] bit_cnt_reg;
  logic             busy_reg;
  logic             match_reg;
  logic             done_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIN_W-1:0] bit_cnt_next;
  logic [PAT_W-1:0] window_bits;
  logic             match_hit;

  // A match needs a full history of fresh bits; fill is reset after each hit
  // so matches never overlap.
  always_comb begin
    bit_cnt_next = bit_cnt_reg + 1'b1;
    window_bits  = {hist_reg, bus.data};
    match_hit    = (fill_reg == FILL_MAX) && (window_bits == pattern_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      win_reg     <= '0;
      hist_reg    <= '0;
      fill_reg    <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      match_reg   <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      match_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (bus.abort) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              pattern_reg <= bus.cfg_pattern;
              win_reg     <= bus.cfg_win_len;
              count_reg   <= '0;
              bit_cnt_reg <= '0;
              fill_reg    <= '0;
              busy_reg    <= 1'b1;
              if (bus.cfg_win_len == '0) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= SCAN;
              end
            end
          end
          SCAN: begin
            if (bus.data_valid) begin
              hist_reg    <= window_bits[PAT_W-2:0];
              bit_cnt_reg <= bit_cnt_next;
              if (match_hit) begin
                match_reg <= 1'b1;
                fill_reg  <= '0;
                if (count_reg != {CNT_W{1'b1}})
                  count_reg <= count_reg + 1'b1;
              end else if (fill_reg != FILL_MAX) begin
                fill_reg <= fill_reg + 1'b1;
              end
              if (bit_cnt_next == win_reg) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.match       = match_reg;
  assign bus.done        = done_reg;
  assign bus.match_count = count_reg;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: a per-cycle vector table plus
// hand-written sequences for saturation and mid-scan reset.
module tb_pattern_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pattern_scan_if #(.PAT_W(4), .WIN_W(8), .CNT_W(4)) bus ();

  pattern_scan_ctrl #(.PAT_W(4), .WIN_W(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       start;
    logic       abort;
    logic [3:0] pat;
    logic [7:0] win;
    logic       data;
    logic       valid;
    logic       busy;
    logic       match;
    logic       done;
    logic [3:0] count;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic st, input logic ab, input logic [3:0] p,
                     input logic [7:0] w, input logic d, input logic v,
                     input logic b, input logic m, input logic dn,
                     input logic [3:0] c);
    vec_t x;
    x.start = st; x.abort = ab; x.pat = p; x.win = w; x.data = d; x.valid = v;
    x.busy = b; x.match = m; x.done = dn; x.count = c;
    vq.push_back(x);
  endtask

  task automatic drive(input logic st, input logic ab, input logic [3:0] p,
                       input logic [7:0] w, input logic d, input logic v);
    bus.start = st; bus.abort = ab; bus.cfg_pattern = p;
    bus.cfg_win_len = w; bus.data = d; bus.data_valid = v;
  endtask

  task automatic check(input string nm, input logic b, input logic m,
                       input logic dn, input logic [3:0] c);
    n_vec++;
    if (bus.busy !== b) begin
      n_err++;
      $display("FAIL %s busy: got %b want %b", nm, bus.busy, b);
    end
    if (bus.match !== m) begin
      n_err++;
      $display("FAIL %s match: got %b want %b", nm, bus.match, m);
    end
    if (bus.done !== dn) begin
      n_err++;
      $display("FAIL %s done: got %b want %b", nm, bus.done, dn);
    end
    if (bus.match_count !== c) begin
      n_err++;
      $display("FAIL %s match_count: got %0d want %0d", nm, bus.match_count, c);
    end
  endtask

  task automatic build_table();
    // 1001 over 1 0 0 1 1 0 0 1: matches at bits 4 and 8, done with the second
    add(1,0,4'h9,8'd8,0,0, 1,0,0,4'd0);
    add(0,0,4'h9,8'd8,1,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd8,0,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd8,0,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd8,1,1, 1,1,0,4'd1);
    add(0,0,4'h9,8'd8,1,1, 1,0,0,4'd1);
    add(0,0,4'h9,8'd8,0,1, 1,0,0,4'd1);
    add(0,0,4'h9,8'd8,0,1, 1,0,0,4'd1);
    add(0,0,4'h9,8'd8,1,1, 1,1,1,4'd2);
    add(0,0,4'h9,8'd8,0,0, 0,0,0,4'd2);
    // 1001 over 1 0 0 1 0 0 1, win 7: overlap not counted; cfg changes and start ignored
    add(1,0,4'h9,8'd7,0,0, 1,0,0,4'd0);
    add(0,0,4'h0,8'd2,1,1, 1,0,0,4'd0);
    add(0,0,4'h0,8'd2,0,1, 1,0,0,4'd0);
    add(1,0,4'h0,8'd2,0,1, 1,0,0,4'd0);
    add(0,0,4'h0,8'd2,1,1, 1,1,0,4'd1);
    add(0,0,4'h0,8'd2,0,1, 1,0,0,4'd1);
    add(0,0,4'h0,8'd2,0,1, 1,0,0,4'd1);
    add(0,0,4'h0,8'd2,1,1, 1,0,1,4'd1);
    add(0,0,4'h0,8'd2,0,0, 0,0,0,4'd1);
    // 1001 over 1 1 _ _ 0 0 1 with a two-cycle valid gap, win 5
    add(1,0,4'h9,8'd5,0,0, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,1,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,1,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,1,0, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,1,0, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,0,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,0,1, 1,0,0,4'd0);
    add(0,0,4'h9,8'd5,1,1, 1,1,1,4'd1);
    add(0,0,4'h9,8'd5,0,0, 0,0,0,4'd1);
    // zero-length window goes straight to DONE; start during DONE ignored
    add(1,0,4'h9,8'd0,0,0, 1,0,1,4'd0);
    add(1,0,4'h9,8'd3,1,1, 0,0,0,4'd0);
    add(0,0,4'h9,8'd3,1,1, 0,0,0,4'd0);
    // abort at bit 3 of a 10-bit window, with start and valid data alongside
    add(1,0,4'hA,8'd10,0,0, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,1,1, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,0,1, 1,0,0,4'd0);
    add(1,1,4'hA,8'd10,1,1, 0,0,0,4'd0);
    add(0,0,4'hA,8'd10,0,1, 0,0,0,4'd0);
    add(0,0,4'hA,8'd10,0,0, 0,0,0,4'd0);
    add(1,1,4'hA,8'd10,0,0, 0,0,0,4'd0);
    // abort after one match keeps the partial count
    add(1,0,4'hA,8'd10,0,0, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,1,1, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,0,1, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,1,1, 1,0,0,4'd0);
    add(0,0,4'hA,8'd10,0,1, 1,1,0,4'd1);
    add(0,1,4'hA,8'd10,1,1, 0,0,0,4'd1);
    add(0,0,4'hA,8'd10,0,0, 0,0,0,4'd1);
  endtask

  initial begin
    drive(0,0,4'h0,8'd0,0,0);
    build_table();

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0,0,0,4'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].start, vq[i].abort, vq[i].pat, vq[i].win, vq[i].data, vq[i].valid);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].busy, vq[i].match, vq[i].done, vq[i].count);
      $display("vec %0d: st=%b ab=%b d=%b v=%b -> busy=%b match=%b done=%b count=%0d",
               i, vq[i].start, vq[i].abort, vq[i].data, vq[i].valid,
               bus.busy, bus.match, bus.done, bus.match_count);
    end

    // 1111 over 255 ones: 63 matches, counter must stop at 15
    drive(1,0,4'hF,8'd255,0,0);
    @(posedge clk);
    #1;
    check("sat_start", 1,0,0,4'd0);
    for (int k = 1; k <= 255; k++) begin
      int exp_c;
      exp_c = (k / 4 > 15) ? 15 : k / 4;
      drive(0,0,4'hF,8'd255,1,1);
      @(posedge clk);
      #1;
      check($sformatf("sat_bit%0d", k), 1'b1, (k % 4) == 0, k == 255, 4'(exp_c));
    end
    drive(0,0,4'hF,8'd255,0,0);
    @(posedge clk);
    #1;
    check("sat_idle", 0,0,0,4'd15);
    $display("saturation scan: 255 bits, final count=%0d", bus.match_count);

    // asynchronous reset in the middle of a scan, right on a match pulse
    drive(1,0,4'hF,8'd20,0,0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      drive(0,0,4'hF,8'd20,1,1);
      @(posedge clk);
    end
    #1;
    check("pre_rst", 1,1,0,4'd1);
    drive(0,0,4'hF,8'd20,0,0);
    rst = 1'b1;
    #1;
    check("async_rst", 0,0,0,4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0,0,4'hF,8'd20,1,1);
    @(posedge clk);
    #1;
    check("post_rst_idle", 0,0,0,4'd0);
    $display("mid-scan reset: busy=%b count=%0d", bus.busy, bus.match_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
